// File: rtl/fpu_addsub_seq.sv
// rtl/fpu_addsub_seq.sv - multicycle IEEE-754 add/subtract; FPU_SPECIAL_CASE_EN enables inf/NaN decode
module fpu_addsub_seq #(
    parameter int W  = 32,
    parameter int EW = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] data_x_i,
    input  logic [W-1:0] data_y_i,
    input  logic         add_subt_i,
    input  logic [1:0]   r_mode_i,
    output logic         busy_o,
    output logic         ready_o,
    output logic [W-1:0] result_o,
    output logic         overflow_o,
    output logic         underflow_o,
    output logic         invalid_o
);

    localparam int SW = W - EW - 1;
    localparam int MW = SW + 4;
    localparam int XW = EW + 2;
    localparam logic signed [XW-1:0] EXP_MAX = {2'b00, {EW{1'b1}}};
    localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   accept;

    logic [W-1:0] x_q, y_q;
    logic         sub_q;
    logic [1:0]   rmode_q;

    logic [EW-1:0] ld_ex, ld_ey;
    logic [SW-1:0] ld_fx, ld_fy;
    logic          ld_sx, ld_sy, ld_swap;
`ifdef FPU_SPECIAL_CASE_EN
    logic          ld_x_inf, ld_y_inf, ld_x_nan, ld_y_nan;
`endif

    logic          sign_a_d, sign_a_q;
    logic          eff_sub_d, eff_sub_q;
    logic [EW-1:0] exp_a_d, exp_a_q;
    logic [EW-1:0] exp_diff_d, exp_diff_q;
    logic [SW:0]   man_a_d, man_a_q;
    logic [SW:0]   man_b_d, man_b_q;
    logic          spec_d, spec_q;
    logic [W-1:0]  spec_res_d, spec_res_q;
    logic          spec_inv_d, spec_inv_q;

    logic [MW-1:0] al_ext, al_lost;
    logic [MW-1:0] aligned_b_d, aligned_b_q;

    logic [MW:0]   sum_d, sum_q;

    int                    nz_lz;
    logic signed [XW-1:0]  nz_exp;
    logic [MW-1:0]         norm_man_d, norm_man_q;
    logic signed [XW-1:0]  norm_exp_d, norm_exp_q;
    logic                  zero_d, zero_q;

    logic                  rd_inc, rd_carry;
    logic [SW-1:0]         rd_frac;
    logic signed [XW-1:0]  rd_exp;
    logic [W-1:0]          res_d, res_q;
    logic                  ovf_d, ovf_q, unf_d, unf_q, inv_d, inv_q;

    logic [W-1:0] result_q;
    logic         ready_q, overflow_q, underflow_q, invalid_q;

    assign accept = start_i && (state_q == S_IDLE || state_q == S_DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: fixed walk through the datapath stages, DONE may chain straight into LOAD
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_LOAD;
            S_LOAD:  state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  state_d = start_i ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request only when the unit is free to take it
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            sub_q   <= 1'b0;
            rmode_q <= 2'b00;
        end else if (accept) begin
            x_q     <= data_x_i;
            y_q     <= data_y_i;
            sub_q   <= add_subt_i;
            rmode_q <= r_mode_i;
        end
    end

    // LOAD: flush denormals, apply subtract, order operands by magnitude, decode specials
    always_comb begin
        ld_ex      = x_q[W-2:SW];
        ld_ey      = y_q[W-2:SW];
        ld_fx      = (ld_ex == '0) ? '0 : x_q[SW-1:0];
        ld_fy      = (ld_ey == '0) ? '0 : y_q[SW-1:0];
        ld_sx      = x_q[W-1];
        ld_sy      = y_q[W-1] ^ sub_q;
        ld_swap    = {ld_ey, ld_fy} > {ld_ex, ld_fx};
        sign_a_d   = ld_swap ? ld_sy : ld_sx;
        eff_sub_d  = ld_sx ^ ld_sy;
        exp_a_d    = ld_swap ? ld_ey : ld_ex;
        exp_diff_d = ld_swap ? (ld_ey - ld_ex) : (ld_ex - ld_ey);
        man_a_d    = ld_swap ? {|ld_ey, ld_fy} : {|ld_ex, ld_fx};
        man_b_d    = ld_swap ? {|ld_ex, ld_fx} : {|ld_ey, ld_fy};
        spec_d     = 1'b0;
        spec_res_d = '0;
        spec_inv_d = 1'b0;
`ifdef FPU_SPECIAL_CASE_EN
        ld_x_inf = (&ld_ex) && (x_q[SW-1:0] == '0);
        ld_y_inf = (&ld_ey) && (y_q[SW-1:0] == '0);
        ld_x_nan = (&ld_ex) && (x_q[SW-1:0] != '0);
        ld_y_nan = (&ld_ey) && (y_q[SW-1:0] != '0);
        if (ld_x_nan || ld_y_nan) begin
            spec_d     = 1'b1;
            spec_res_d = QNAN;
        end else if (ld_x_inf && ld_y_inf) begin
            spec_d = 1'b1;
            if (ld_sx != ld_sy) begin
                spec_res_d = QNAN;
                spec_inv_d = 1'b1;
            end else begin
                spec_res_d = {ld_sx, {EW{1'b1}}, {SW{1'b0}}};
            end
        end else if (ld_x_inf) begin
            spec_d     = 1'b1;
            spec_res_d = {ld_sx, {EW{1'b1}}, {SW{1'b0}}};
        end else if (ld_y_inf) begin
            spec_d     = 1'b1;
            spec_res_d = {ld_sy, {EW{1'b1}}, {SW{1'b0}}};
        end
`endif
    end

    // ALIGN: shift B right into guard/round/sticky, collapsing far-away operands to sticky
    always_comb begin
        al_ext  = {man_b_q, 3'b000};
        al_lost = al_ext & ~({MW{1'b1}} << exp_diff_q);
        if (int'(exp_diff_q) >= MW)
            aligned_b_d = {{(MW-1){1'b0}}, |man_b_q};
        else
            aligned_b_d = (al_ext >> exp_diff_q) | {{(MW-1){1'b0}}, |al_lost};
    end

    // ADD: |A| >= |B| so the subtraction never goes negative
    always_comb begin
        if (eff_sub_q) sum_d = {1'b0, man_a_q, 3'b000} - {1'b0, aligned_b_q};
        else           sum_d = {1'b0, man_a_q, 3'b000} + {1'b0, aligned_b_q};
    end

    // NORM: fold a carry back down, or pull the leading one up to the hidden position
    always_comb begin
        nz_lz = MW;
        for (int i = 0; i < MW; i++) begin
            if (sum_q[i]) nz_lz = MW - 1 - i;
        end
        nz_exp     = {2'b00, exp_a_q};
        norm_man_d = '0;
        norm_exp_d = '0;
        zero_d     = 1'b0;
        if (sum_q[MW]) begin
            norm_man_d = {sum_q[MW:2], |sum_q[1:0]};
            norm_exp_d = nz_exp + XW'(1);
        end else if (sum_q == '0) begin
            zero_d = 1'b1;
        end else begin
            norm_man_d = sum_q[MW-1:0] << nz_lz;
            norm_exp_d = nz_exp - XW'(nz_lz);
        end
    end

    // ROUND: mode-dependent increment, then saturate or flush on the final exponent
    always_comb begin
        case (rmode_q)
            2'b00:   rd_inc = norm_man_q[2] & (norm_man_q[1] | norm_man_q[0] | norm_man_q[3]);
            2'b01:   rd_inc = 1'b0;
            2'b10:   rd_inc = ~sign_a_q & (|norm_man_q[2:0]);
            default: rd_inc = sign_a_q & (|norm_man_q[2:0]);
        endcase
        rd_frac  = norm_man_q[MW-2:3] + {{(SW-1){1'b0}}, rd_inc};
        rd_carry = rd_inc & (&norm_man_q[MW-1:3]);
        rd_exp   = rd_carry ? (norm_exp_q + XW'(1)) : norm_exp_q;
        res_d    = {sign_a_q, rd_exp[EW-1:0], rd_frac};
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        inv_d    = 1'b0;
        if (zero_q) begin
            res_d = {(rmode_q == 2'b11), {(W-1){1'b0}}};
        end else if (rd_exp >= EXP_MAX) begin
            ovf_d = 1'b1;
            res_d = {sign_a_q, {EW{1'b1}}, {SW{1'b0}}};
        end else if (rd_exp[XW-1] || rd_exp == '0) begin
            unf_d = 1'b1;
            res_d = {sign_a_q, {(W-1){1'b0}}};
        end
        if (spec_q) begin
            res_d = spec_res_q;
            ovf_d = 1'b0;
            unf_d = 1'b0;
            inv_d = spec_inv_q;
        end
    end

    // Pipeline registers, each stage written only while the FSM sits in it
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_a_q    <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_a_q     <= '0;
            exp_diff_q  <= '0;
            man_a_q     <= '0;
            man_b_q     <= '0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            spec_inv_q  <= 1'b0;
            aligned_b_q <= '0;
            sum_q       <= '0;
            norm_man_q  <= '0;
            norm_exp_q  <= '0;
            zero_q      <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    sign_a_q   <= sign_a_d;
                    eff_sub_q  <= eff_sub_d;
                    exp_a_q    <= exp_a_d;
                    exp_diff_q <= exp_diff_d;
                    man_a_q    <= man_a_d;
                    man_b_q    <= man_b_d;
                    spec_q     <= spec_d;
                    spec_res_q <= spec_res_d;
                    spec_inv_q <= spec_inv_d;
                end
                S_ALIGN: aligned_b_q <= aligned_b_d;
                S_ADD:   sum_q <= sum_d;
                S_NORM: begin
                    norm_man_q <= norm_man_d;
                    norm_exp_q <= norm_exp_d;
                    zero_q     <= zero_d;
                end
                S_ROUND: begin
                    res_q <= res_d;
                    ovf_q <= ovf_d;
                    unf_q <= unf_d;
                    inv_q <= inv_d;
                end
                default: ;
            endcase
        end
    end

    // Output register: publish result and flags with a one-cycle ready pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            invalid_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (state_q == S_DONE) begin
                ready_q     <= 1'b1;
                result_q    <= res_q;
                overflow_q  <= ovf_q;
                underflow_q <= unf_q;
                invalid_q   <= inv_q;
            end
        end
    end

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign ready_o     = ready_q;
    assign result_o    = result_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign invalid_o   = invalid_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb/tb_fpu_addsub_seq.sv - self-checking bench for fpu_addsub_seq (single precision)
module tb_fpu_addsub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] data_x_i, data_y_i;
    logic        add_subt_i;
    logic [1:0]  r_mode_i;
    logic        busy_o, ready_o, overflow_o, underflow_o, invalid_o;
    logic [31:0] result_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    fpu_addsub_seq #(.W(32), .EW(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .data_x_i(data_x_i), .data_y_i(data_y_i),
        .add_subt_i(add_subt_i), .r_mode_i(r_mode_i),
        .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o), .invalid_o(invalid_o)
    );

    always #5 clk = ~clk;

    // Exact reference: align both operands as wide integers (units of 2^-149), add, round once
    function automatic logic [31:0] ref_addsub(input logic [31:0] x, input logic [31:0] y,
                                               input logic sub, input logic [1:0] rm,
                                               output logic ovf, output logic unf,
                                               output logic inv);
        logic         sx, sy, s, inc;
        int           ex, ey, p, sh, e_res;
        logic [299:0] ax, ay, mag, kept, rem, half;
`ifdef FPU_SPECIAL_CASE_EN
        logic         xn, yn, xi, yi;
`endif
        ovf = 1'b0; unf = 1'b0; inv = 1'b0;
        sx = x[31];
        sy = y[31] ^ sub;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
`ifdef FPU_SPECIAL_CASE_EN
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        if (xn || yn) return 32'h7FC00000;
        if (xi && yi) begin
            if (sx != sy) begin
                inv = 1'b1;
                return 32'h7FC00000;
            end
            return {sx, 8'hFF, 23'h0};
        end
        if (xi) return {sx, 8'hFF, 23'h0};
        if (yi) return {sy, 8'hFF, 23'h0};
`endif
        ax = (ex == 0) ? '0 : (300'({1'b1, x[22:0]}) << (ex - 1));
        ay = (ey == 0) ? '0 : (300'({1'b1, y[22:0]}) << (ey - 1));
        if (sx == sy)      begin mag = ax + ay; s = sx; end
        else if (ax >= ay) begin mag = ax - ay; s = sx; end
        else               begin mag = ay - ax; s = sy; end
        if (mag == '0) return {(rm == 2'b11), 31'h0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p >= 23) begin
            sh   = p - 23;
            kept = mag >> sh;
            rem  = mag & ((300'(1) << sh) - 300'(1));
        end else begin
            sh   = 0;
            kept = mag << (23 - p);
            rem  = '0;
        end
        half = (sh > 0) ? (300'(1) << (sh - 1)) : '0;
        case (rm)
            2'b00:   inc = (rem != 0) && ((rem > half) || (rem == half && kept[0]));
            2'b01:   inc = 1'b0;
            2'b10:   inc = (rem != 0) && !s;
            default: inc = (rem != 0) && s;
        endcase
        e_res = p - 22;
        kept  = kept + 300'(inc);
        if (kept[24]) begin
            kept  = kept >> 1;
            e_res = e_res + 1;
        end
        if (e_res >= 255) begin
            ovf = 1'b1;
            return {s, 8'hFF, 23'h0};
        end
        if (e_res <= 0) begin
            unf = 1'b1;
            return {s, 31'h0};
        end
        return {s, 8'(e_res), kept[22:0]};
    endfunction

    // Issue one request at the current (post-edge) time and wait for its ready pulse
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sub,
                          input logic [1:0] rm, output logic [31:0] r, output logic [2:0] f,
                          output int lat, output logic [6:0] bh);
        data_x_i = x; data_y_i = y; add_subt_i = sub; r_mode_i = rm; start_i = 1'b1;
        bh = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        bh[0] = busy_o;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k < 7) bh[k] = busy_o;
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        r = result_o;
        f = {overflow_o, underflow_o, invalid_o};
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; data_x_i = '0; data_y_i = '0;
        add_subt_i = 1'b0; r_mode_i = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        vec_cnt++;
        if (result_o !== 32'h0) begin
            err_cnt++; $display("FAIL reset_result: got %h want 00000000", result_o);
        end
        vec_cnt++;
        if ({busy_o, ready_o, overflow_o, underflow_o, invalid_o} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {busy_o, ready_o, overflow_o, underflow_o, invalid_o});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        sub;
        logic [1:0]  rm;
        logic [31:0] r;
        logic [2:0]  f;
    } vec_t;

    task automatic test_directed();
        vec_t        tbl [9];
        logic [31:0] r;
        logic [2:0]  f;
        logic [6:0]  bh;
        int          lat;
        tbl[0] = '{32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000, 3'b000};
        tbl[1] = '{32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 32'h00000000, 3'b000};
        tbl[2] = '{32'h3F800000, 32'h3F800000, 1'b1, 2'b11, 32'h80000000, 3'b000};
        tbl[3] = '{32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000, 3'b000};
        tbl[4] = '{32'h3F800000, 32'h33800000, 1'b0, 2'b10, 32'h3F800001, 3'b000};
        tbl[5] = '{32'h3F800000, 32'h33800000, 1'b0, 2'b01, 32'h3F800000, 3'b000};
        tbl[6] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000, 3'b100};
        tbl[7] = '{32'h00800000, 32'h00800001, 1'b1, 2'b00, 32'h80000000, 3'b010};
        tbl[8] = '{32'h00000001, 32'h3F800000, 1'b0, 2'b00, 32'h3F800000, 3'b000};
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].x, tbl[i].y, tbl[i].sub, tbl[i].rm, r, f, lat, bh);
            vec_cnt++;
            if (lat !== 6) begin
                err_cnt++; $display("FAIL dir%0d_latency: got %0d want 6", i, lat);
            end
            vec_cnt++;
            if (r !== tbl[i].r) begin
                err_cnt++; $display("FAIL dir%0d_result: got %h want %h", i, r, tbl[i].r);
            end
            vec_cnt++;
            if (f !== tbl[i].f) begin
                err_cnt++; $display("FAIL dir%0d_flags: got %b want %b", i, f, tbl[i].f);
            end
            if (i == 0) begin
                vec_cnt++;
                if (bh !== 7'b0011111) begin
                    err_cnt++; $display("FAIL busy_profile: got %b want 0011111", bh);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] r;
        logic [2:0]  f;
        logic [6:0]  bh;
        int          lat, pulses;
        run_op(32'h40A00000, 32'h3F800000, 1'b1, 2'b00, r, f, lat, bh);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (ready_o) pulses++;
        end
        vec_cnt++;
        if (result_o !== 32'h40800000 || pulses != 0) begin
            err_cnt++;
            $display("FAIL hold: got %h/%0d pulses want 40800000/0", result_o, pulses);
        end
    endtask

    task automatic test_special();
        logic [31:0] r;
        logic [2:0]  f;
        logic [6:0]  bh;
        int          lat;
        run_op(32'h7F800000, 32'h7F800000, 1'b1, 2'b00, r, f, lat, bh);
`ifdef FPU_SPECIAL_CASE_EN
        vec_cnt++;
        if (r !== 32'h7FC00000 || f !== 3'b001 || lat !== 6) begin
            err_cnt++; $display("FAIL inf_minus_inf: got %h %b lat %0d want 7fc00000 001 6", r, f, lat);
        end
        run_op(32'h7FC12345, 32'h3F800000, 1'b0, 2'b00, r, f, lat, bh);
        vec_cnt++;
        if (r !== 32'h7FC00000 || f !== 3'b000) begin
            err_cnt++; $display("FAIL nan_in: got %h %b want 7fc00000 000", r, f);
        end
        run_op(32'h3F800000, 32'h7F800000, 1'b1, 2'b00, r, f, lat, bh);
        vec_cnt++;
        if (r !== 32'hFF800000 || f !== 3'b000) begin
            err_cnt++; $display("FAIL inf_in: got %h %b want ff800000 000", r, f);
        end
`else
        vec_cnt++;
        if (r !== 32'h00000000 || f !== 3'b000 || lat !== 6) begin
            err_cnt++; $display("FAIL inf_minus_inf: got %h %b lat %0d want 00000000 000 6", r, f, lat);
        end
`endif
    endtask

    function automatic logic [31:0] rand_y(input logic [31:0] x);
        logic [31:0] y;
        int          e;
        y = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: begin
                e = int'(x[30:23]) + int'($urandom_range(0, 6)) - 3;
                if (e < 0) e = 0;
                if (e > 255) e = 255;
                y[30:23] = 8'(e);
            end
            2: begin
                y = x ^ {1'b0, 26'h0, 5'($urandom)};
                y[31] = $urandom_range(0, 1);
            end
            default: begin
                e = int'(x[30:23]) - int'($urandom_range(20, 30));
                y[30:23] = (e < 1) ? 8'd1 : 8'(e);
            end
        endcase
        return y;
    endfunction

    task automatic test_random();
        logic [31:0] x, y, r, er;
        logic [2:0]  f;
        logic [6:0]  bh;
        logic        sub, o, u, iv;
        logic [1:0]  rm;
        int          lat;
        for (int n = 0; n < 250; n++) begin
            x   = $urandom;
            y   = rand_y(x);
            sub = $urandom_range(0, 1);
            rm  = 2'($urandom_range(0, 3));
            er  = ref_addsub(x, y, sub, rm, o, u, iv);
            run_op(x, y, sub, rm, r, f, lat, bh);
            vec_cnt++;
            if (r !== er || f !== {o, u, iv} || lat !== 6) begin
                err_cnt++;
                $display("FAIL rand%0d %h %s %h m%0d: got %h %b lat %0d want %h %b 6",
                         n, x, sub ? "-" : "+", y, rm, r, f, lat, er, {o, u, iv});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x1, y1, x2, y2, e1, e2;
        logic        o1, u1, i1, o2, u2, i2;
        int          lat;
        for (int n = 0; n < 4; n++) begin
            x1 = $urandom; y1 = rand_y(x1);
            x2 = $urandom; y2 = rand_y(x2);
            e1 = ref_addsub(x1, y1, 1'b0, 2'b00, o1, u1, i1);
            e2 = ref_addsub(x2, y2, 1'b1, 2'b01, o2, u2, i2);
            data_x_i = x1; data_y_i = y1; add_subt_i = 1'b0; r_mode_i = 2'b00; start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            repeat (5) begin @(posedge clk); #1; end
            vec_cnt++;
            if (busy_o !== 1'b0) begin
                err_cnt++; $display("FAIL b2b%0d_done_busy: got %b want 0", n, busy_o);
            end
            data_x_i = x2; data_y_i = y2; add_subt_i = 1'b1; r_mode_i = 2'b01; start_i = 1'b1;
            @(posedge clk); #1;
            start_i = 1'b0;
            vec_cnt++;
            if (ready_o !== 1'b1 || result_o !== e1 || {overflow_o, underflow_o, invalid_o} !== {o1, u1, i1}) begin
                err_cnt++;
                $display("FAIL b2b%0d_first: got rdy %b %h want rdy 1 %h", n, ready_o, result_o, e1);
            end
            lat = 99;
            for (int k = 1; k <= 20; k++) begin
                @(posedge clk); #1;
                if (ready_o) begin lat = k; break; end
            end
            vec_cnt++;
            if (lat !== 6 || result_o !== e2 || {overflow_o, underflow_o, invalid_o} !== {o2, u2, i2}) begin
                err_cnt++;
                $display("FAIL b2b%0d_second: got %h lat %0d want %h lat 6", n, result_o, lat, e2);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat, pulses;
        data_x_i = 32'h3F800000; data_y_i = 32'h40000000; add_subt_i = 1'b0;
        r_mode_i = 2'b00; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) begin
                data_x_i = 32'h41200000; data_y_i = 32'h40800000; add_subt_i = 1'b1;
                start_i = 1'b1;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
            if (ready_o) begin lat = k; break; end
        end
        vec_cnt++;
        if (lat !== 6 || result_o !== 32'h40400000) begin
            err_cnt++; $display("FAIL busy_ignore: got %h lat %0d want 40400000 lat 6", result_o, lat);
        end
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (ready_o) pulses++;
        end
        vec_cnt++;
        if (pulses != 0) begin
            err_cnt++; $display("FAIL busy_ignore_extra: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        data_x_i = 32'h40400000; data_y_i = 32'h3F800000; add_subt_i = 1'b0;
        r_mode_i = 2'b00; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vec_cnt++;
        if ({busy_o, ready_o, overflow_o, underflow_o, invalid_o} !== 5'b0 || result_o !== 32'h0) begin
            err_cnt++;
            $display("FAIL reset_mid_outputs: got %b %h want 00000 00000000",
                     {busy_o, ready_o, overflow_o, underflow_o, invalid_o}, result_o);
        end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (ready_o) pulses++;
        end
        vec_cnt++;
        if (pulses != 0 || busy_o !== 1'b0) begin
            err_cnt++; $display("FAIL reset_mid_pulse: got %0d pulses busy %b want 0 0", pulses, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_special();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
